dmem_ctrl: RTL

- MEM-stage data-memory access controller.
- Takes MEM-stage control and data from the EX/MEM register: ALUResult as the address, ReadData2 as the store data.
- Drives a req/ack data-memory bus and returns MemReadData and StallController to the MEM/WB register and the hazard controller.
- Handles byte/half/word lane alignment, sign extension, misalignment traps and LL/SC linking.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/dmem_align.sv | 51 +++++
 rtl/dmem_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage data-memory controller.
// Holds the FSM state encoding, byte-enable patterns and the bus timeout limit.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;

  localparam logic [7:0] TIMEOUT_MAX = 8'd255;

  // A half needs addr[0]=0, a word needs addr[1:0]=0; bytes are always aligned.
  function automatic logic is_misaligned(input logic half, input logic is_byte,
                                         input logic [1:0] lo);
    return (half & lo[0]) | (~half & ~is_byte & (lo != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Lane steering for the data-memory bus: store data replication and byte enables
// from the live address, and load lane extraction plus zero/sign extension from
// the latched address. Purely combinational.
module dmem_align
  import mem_pkg::*;
(
  input  logic [1:0]  st_lo_i,
  input  logic        st_half_i,
  input  logic        st_byte_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o,
  input  logic [1:0]  ld_lo_i,
  input  logic        ld_half_i,
  input  logic        ld_byte_i,
  input  logic        ld_sext_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  // Store side: replicate the datum across all lanes, enable only the target lanes.
  always_comb begin
    wdata_o = st_data_i;
    be_o    = BE_WORD;
    if (st_byte_i) begin
      wdata_o = {4{st_data_i[7:0]}};
      be_o    = 4'b0001 << st_lo_i;
    end else if (st_half_i) begin
      wdata_o = {2{st_data_i[15:0]}};
      be_o    = st_lo_i[1] ? BE_HALF_HI : BE_HALF_LO;
    end
  end

  // Load side: pick the addressed lane and extend it to 32 bits.
  always_comb begin
    case (ld_lo_i)
      2'd1:    ld_b = rdata_i[15:8];
      2'd2:    ld_b = rdata_i[23:16];
      2'd3:    ld_b = rdata_i[31:24];
      default: ld_b = rdata_i[7:0];
    endcase
    ld_h = ld_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    if (ld_byte_i)      ld_data_o = {{24{ld_sext_i & ld_b[7]}}, ld_b};
    else if (ld_half_i) ld_data_o = {{16{ld_sext_i & ld_h[15]}}, ld_h};
    else                ld_data_o = rdata_i;
  end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory controller: req/ack bus master with lane alignment,
// misalignment traps and LL/SC link tracking. IDLE -> BUSY (until ack) -> DONE.
// Optional bus timeout in BUSY is enabled by defining DMEM_TIMEOUT_EN.
module dmem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W            = 32,
  parameter bit LINK_ON_ANY_STORE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              MemHalf,
  input  logic              MemByte,
  input  logic              MemSignExtend,
  input  logic              LLSC,
  input  logic [ADDR_W-1:0] ALUResult,
  input  logic [31:0]       ReadData2,
  output logic [31:0]       MemReadData,
  output logic              StallController,
  output logic              AddrErrLoad,
  output logic              AddrErrStore,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack
);

  dmem_state_t       state_q;
  logic              req_q, we_q, ll_q, sc_q, flushed_q;
  logic              ld_half_q, ld_byte_q, ld_sext_q;
  logic [1:0]        ld_lo_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q, rdata_q;
  logic              link_valid_q;
  logic [ADDR_W-3:0] link_addr_q;

  logic        access, is_byte, is_half, misal, sc_req, ll_req, link_hit, go, flushed;
  logic [31:0] st_wdata, ld_data;
  logic [3:0]  st_be;
  logic        tmo_fire;

  assign access   = (MemRead | MemWrite) & ~Flush;
  assign is_byte  = MemByte;
  assign is_half  = MemHalf & ~MemByte;
  assign misal    = access & is_misaligned(is_half, is_byte, ALUResult[1:0]);
  assign sc_req   = MemWrite & LLSC;
  assign ll_req   = MemRead & ~MemWrite & LLSC;
  assign link_hit = link_valid_q & (link_addr_q == ALUResult[ADDR_W-1:2]);
  assign go       = (state_q == IDLE) & access & ~misal;
  // A flush seen at any point of the bus transaction kills its result.
  assign flushed  = flushed_q | Flush;

`ifdef DMEM_TIMEOUT_EN
  logic [7:0] tmo_cnt_q;
  assign tmo_fire = (state_q == BUSY) & ~dmem_ack & (tmo_cnt_q == TIMEOUT_MAX);
`else
  assign tmo_fire = 1'b0;
`endif

  assign AddrErrLoad     = ((state_q == IDLE) & misal & ~MemWrite) | (tmo_fire & ~we_q);
  assign AddrErrStore    = ((state_q == IDLE) & misal &  MemWrite) | (tmo_fire &  we_q);
  assign StallController = go | ((state_q == BUSY) & ~tmo_fire);

  assign MemReadData = rdata_q;
  assign dmem_req    = req_q;
  assign dmem_we     = we_q;
  assign dmem_addr   = addr_q;
  assign dmem_be     = be_q;
  assign dmem_wdata  = wdata_q;

  dmem_align u_align (
    .st_lo_i   (ALUResult[1:0]),
    .st_half_i (is_half),
    .st_byte_i (is_byte),
    .st_data_i (ReadData2),
    .wdata_o   (st_wdata),
    .be_o      (st_be),
    .ld_lo_i   (ld_lo_q),
    .ld_half_i (ld_half_q),
    .ld_byte_i (ld_byte_q),
    .ld_sext_i (ld_sext_q),
    .rdata_i   (dmem_rdata),
    .ld_data_o (ld_data)
  );

  // Access FSM: latch the bus request, hold it until ack, then park the result in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      be_q      <= 4'b0000;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      rdata_q   <= 32'd0;
      ll_q      <= 1'b0;
      sc_q      <= 1'b0;
      flushed_q <= 1'b0;
      ld_lo_q   <= 2'd0;
      ld_half_q <= 1'b0;
      ld_byte_q <= 1'b0;
      ld_sext_q <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      tmo_cnt_q <= 8'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (go) begin
            if (sc_req & ~link_hit) begin
              // Failed SC never touches the bus.
              rdata_q <= 32'd0;
              state_q <= DONE;
            end else begin
              req_q     <= 1'b1;
              we_q      <= MemWrite;
              addr_q    <= {ALUResult[ADDR_W-1:2], 2'b00};
              be_q      <= st_be;
              wdata_q   <= st_wdata;
              ld_lo_q   <= ALUResult[1:0];
              ld_half_q <= is_half;
              ld_byte_q <= is_byte;
              ld_sext_q <= MemSignExtend;
              ll_q      <= ll_req;
              sc_q      <= sc_req;
              flushed_q <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
              tmo_cnt_q <= 8'd0;
`endif
              state_q   <= BUSY;
            end
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            be_q      <= 4'b0000;
            flushed_q <= 1'b0;
            if (flushed) begin
              state_q <= IDLE;
            end else begin
              state_q <= DONE;
              if (sc_q)       rdata_q <= 32'd1;
              else if (!we_q) rdata_q <= ld_data;
            end
          end else begin
            if (Flush) flushed_q <= 1'b1;
`ifdef DMEM_TIMEOUT_EN
            if (tmo_fire) begin
              req_q     <= 1'b0;
              we_q      <= 1'b0;
              be_q      <= 4'b0000;
              flushed_q <= 1'b0;
              state_q   <= IDLE;
            end else begin
              tmo_cnt_q <= tmo_cnt_q + 8'd1;
            end
`endif
          end
        end
        DONE: begin
          if (!Stall) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // LL/SC link: set by a completed LL, cleared by any SC, matching stores, or flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
    end else begin
      if ((state_q == IDLE) & sc_req & (misal | (go & ~link_hit)))
        link_valid_q <= 1'b0;
      if ((state_q == BUSY) & dmem_ack & ~flushed) begin
        if (ll_q) begin
          link_valid_q <= 1'b1;
          link_addr_q  <= addr_q[ADDR_W-1:2];
        end
        if (sc_q) link_valid_q <= 1'b0;
        if (LINK_ON_ANY_STORE && we_q && (addr_q[ADDR_W-1:2] == link_addr_q))
          link_valid_q <= 1'b0;
      end
      if (Flush) link_valid_q <= 1'b0;
    end
  end

endmodule
